// File: rtl/sequenciador_varredura.sv
// Sweeps the mux select across every channel of an owned input bank and hands each sample downstream over valid/ready.
// Optional comparator of saida_mux against the bank is built only when CHECAGEM_MUX_EN is defined.
module sequenciador_varredura #(
   parameter int  LARGURA     = 8,
   parameter int  CANAIS      = 8,
   parameter int  PERMANENCIA = 1,
   localparam int SEL_W       = $clog2(CANAIS)
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic                            escrita_en,
   input  logic [SEL_W-1:0]                escrita_end,
   input  logic [LARGURA-1:0]              escrita_dado,
   input  logic                            iniciar,
   output logic [CANAIS-1:0][LARGURA-1:0]  entrada,
   output logic [SEL_W-1:0]                seletor,
   input  logic [LARGURA-1:0]              saida_mux,
   output logic [LARGURA-1:0]              amostra_dado,
   output logic [SEL_W-1:0]                amostra_canal,
   output logic                            amostra_valida,
   input  logic                            amostra_pronta,
   output logic                            ocupado,
   output logic                            concluido,
   output logic                            erro_mux
);

   localparam int                CNT_W   = (PERMANENCIA > 1) ? $clog2(PERMANENCIA) : 1;
   localparam logic [CNT_W-1:0]  CNT_FIM = CNT_W'(PERMANENCIA - 1);
   localparam logic [SEL_W-1:0]  SEL_FIM = SEL_W'(CANAIS - 1);

   typedef enum logic [1:0] {OCIOSO, SELECIONA, AMOSTRA, ENTREGA} estado_t;

   estado_t                         r_estado;
   logic [CANAIS-1:0][LARGURA-1:0]  r_banco;
   logic [SEL_W-1:0]                r_sel;
   logic [SEL_W-1:0]                r_canal;
   logic [CNT_W-1:0]                r_cnt;
   logic [LARGURA-1:0]              r_dado;
   logic                            r_valida;
   logic                            r_concl;
   logic                            w_entrega;

   assign w_entrega = r_valida && amostra_pronta;

   // Input bank; a write on the AMOSTRA edge lands after the mux output was captured.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_banco <= '0;
      end else if (escrita_en) begin
         r_banco[escrita_end] <= escrita_dado;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_estado <= OCIOSO;
         r_sel    <= '0;
         r_cnt    <= '0;
         r_dado   <= '0;
         r_canal  <= '0;
         r_valida <= 1'b0;
         r_concl  <= 1'b0;
      end else begin
         r_concl <= 1'b0;
         case (r_estado)
            OCIOSO: begin
               if (iniciar) begin
                  r_sel    <= '0;
                  r_cnt    <= '0;
                  r_estado <= SELECIONA;
               end
            end
            SELECIONA: begin
               if (r_cnt == CNT_FIM) begin
                  r_estado <= AMOSTRA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            AMOSTRA: begin
               r_dado   <= saida_mux;
               r_canal  <= r_sel;
               r_valida <= 1'b1;
               r_estado <= ENTREGA;
            end
            ENTREGA: begin
               if (w_entrega) begin
                  r_valida <= 1'b0;
                  if (r_sel == SEL_FIM) begin
                     r_sel    <= '0;
                     r_concl  <= 1'b1;
                     r_estado <= OCIOSO;
                  end else begin
                     r_sel    <= r_sel + 1'b1;
                     r_cnt    <= '0;
                     r_estado <= SELECIONA;
                  end
               end
            end
            default: r_estado <= OCIOSO;
         endcase
      end
   end

`ifdef CHECAGEM_MUX_EN
   logic r_erro;
   logic w_diverge;

   assign w_diverge = (saida_mux != r_banco[r_sel]);

   // Sticky until reset: one bad mux read is enough to flag the path.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_erro <= 1'b0;
      end else if (r_estado == AMOSTRA && w_diverge) begin
         r_erro <= 1'b1;
      end
   end

   assign erro_mux = r_erro;
`else
   assign erro_mux = 1'b0;
`endif

   assign entrada        = r_banco;
   assign seletor        = r_sel;
   assign amostra_dado   = r_dado;
   assign amostra_canal  = r_canal;
   assign amostra_valida = r_valida;
   assign ocupado        = (r_estado != OCIOSO);
   assign concluido      = r_concl;

endmodule
